phy_reg_ready_table: RTL and testbench



---
 rtl/phy_reg_ready_table_pkg.sv | 29 ++
 rtl/phy_reg_ready_table_feedback_match.sv | 31 +++
 rtl/phy_reg_ready_table.sv | 111 +++++++++++
 tb/tb_phy_reg_ready_table.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_reg_ready_table_pkg.sv
// ----------------------------------------------------------------------------
// phy_reg_ready_table_pkg
// Shared sizing constants and the execute writeback feedback types used by the
// physical-register ready table.
//   PHY_REG_NUM          : number of physical registers (power of two)
//   RENAME_WIDTH         : destination allocations per cycle from rename
//   READ_PORT_NUM        : issue-side readiness query ports
//   FEEDBACK_CHANNEL_NUM : channels in execute_feedback_pack (ALU, BRU, CSR,
//                          DIV, LSU, MUL order; sum of all unit counts)
// ----------------------------------------------------------------------------
package phy_reg_ready_table_pkg;

    localparam int PHY_REG_NUM          = 128;
    localparam int RENAME_WIDTH         = 4;
    localparam int READ_PORT_NUM        = 8;
    localparam int FEEDBACK_CHANNEL_NUM = 8;

    localparam int PHY_ID_W = $clog2(PHY_REG_NUM);
    localparam int VALUE_W  = 32;

    typedef struct packed {
        logic                enable;
        logic [PHY_ID_W-1:0] phy_id;
        logic [VALUE_W-1:0]  value;
    } execute_feedback_channel_t;

    typedef execute_feedback_channel_t [FEEDBACK_CHANNEL_NUM-1:0] execute_feedback_pack_t;

endpackage

// File: rtl/phy_reg_ready_table_feedback_match.sv
// ----------------------------------------------------------------------------
// phy_reg_ready_table_feedback_match
// Reports whether any enabled feedback channel targets the given register.
// Used once per read port to form the zero-cycle wakeup bypass.
//   execute_feedback_pack : merged writeback feedback from all execute units
//   phy_id                : register being queried
//   hit                   : 1 when some enabled channel carries phy_id
// ----------------------------------------------------------------------------
module phy_reg_ready_table_feedback_match
    import phy_reg_ready_table_pkg::*;
(
    input  execute_feedback_pack_t execute_feedback_pack,
    input  logic [PHY_ID_W-1:0]    phy_id,
    output logic                   hit
);

    // Result values travel in the same pack but play no part in readiness.
    logic unused_value;

    always_comb begin
        hit          = 1'b0;
        unused_value = 1'b0;
        for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
            if (execute_feedback_pack[c].enable && (execute_feedback_pack[c].phy_id == phy_id)) begin
                hit = 1'b1;
            end
            unused_value = unused_value ^ (^execute_feedback_pack[c].value);
        end
    end

endmodule

// File: rtl/phy_reg_ready_table.sv
// ----------------------------------------------------------------------------
// phy_reg_ready_table
// Per-physical-register ready bit for the out-of-order core. Rename clears the
// bit of each newly allocated destination, execute feedback sets it, and a
// flush marks every register ready (only committed mappings survive).
// Register 0 is permanently ready.
//   clk                   : core clock
//   rst                   : asynchronous, active-low reset (table -> all ones)
//   execute_feedback_pack : per-channel enable/phy_id/value writeback feedback
//   rename_alloc_valid    : allocation slot valid
//   rename_alloc_phy_id   : allocated destination register per slot
//   flush                 : pipeline flush from commit
//   read_phy_id           : issue-side query register per port
//   read_ready            : combinational readiness, feedback bypassed in
//   ready_bitmap          : registered table contents
// ----------------------------------------------------------------------------
module phy_reg_ready_table
    import phy_reg_ready_table_pkg::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  execute_feedback_pack_t                       execute_feedback_pack,
    input  logic [RENAME_WIDTH-1:0]                      rename_alloc_valid,
    input  logic [RENAME_WIDTH-1:0][PHY_ID_W-1:0]        rename_alloc_phy_id,
    input  logic                                         flush,
    input  logic [READ_PORT_NUM-1:0][PHY_ID_W-1:0]       read_phy_id,
    output logic [READ_PORT_NUM-1:0]                     read_ready,
    output logic [PHY_REG_NUM-1:0]                       ready_bitmap
);

    logic [PHY_REG_NUM-1:0] ready_q;
    logic [PHY_REG_NUM-1:0] ready_d;
    logic [PHY_REG_NUM-1:0] alloc_hit;
    logic [PHY_REG_NUM-1:0] fb_hit;
    logic [READ_PORT_NUM-1:0] bypass_hit;

    // Decode allocations and feedback into one-hot-per-register vectors.
    // Register 0 is masked out of both so it can never be cleared.
    always_comb begin
        alloc_hit = '0;
        fb_hit    = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (rename_alloc_valid[i]) begin
                alloc_hit[rename_alloc_phy_id[i]] = 1'b1;
            end
        end
        for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
            if (execute_feedback_pack[c].enable) begin
                fb_hit[execute_feedback_pack[c].phy_id] = 1'b1;
            end
        end
        alloc_hit[0] = 1'b0;
        fb_hit[0]    = 1'b0;
    end

    // Priority: flush, then allocate clear, then feedback set, else hold.
    always_comb begin
        if (flush) begin
            ready_d = '1;
        end else begin
            ready_d = (ready_q | fb_hit) & ~alloc_hit;
        end
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready_bitmap = ready_q;

    // Feedback is bypassed into the read ports; same-cycle allocation clears
    // are deliberately not, since rename and issue of one instruction never
    // coincide.
    for (genvar p = 0; p < READ_PORT_NUM; p++) begin : g_read
        phy_reg_ready_table_feedback_match u_match (
            .execute_feedback_pack (execute_feedback_pack),
            .phy_id                (read_phy_id[p]),
            .hit                   (bypass_hit[p])
        );
        assign read_ready[p] = ready_q[read_phy_id[p]] | bypass_hit[p];
    end

`ifndef SYNTHESIS
    logic dup_alloc;

    always_comb begin
        dup_alloc = 1'b0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            for (int j = i + 1; j < RENAME_WIDTH; j++) begin
                if (rename_alloc_valid[i] && rename_alloc_valid[j] &&
                    (rename_alloc_phy_id[i] == rename_alloc_phy_id[j]) &&
                    (rename_alloc_phy_id[i] != '0)) begin
                    dup_alloc = 1'b1;
                end
            end
        end
    end

    a_no_dup_alloc: assert property (@(posedge clk) disable iff (!rst) !dup_alloc)
        else $error("phy_reg_ready_table: two rename slots allocated the same register");

    a_no_alloc_fb_clash: assert property (@(posedge clk) disable iff (!rst) !(|(alloc_hit & fb_hit)))
        else $error("phy_reg_ready_table: allocate and feedback hit the same register");
`endif

endmodule

// File: tb/tb_phy_reg_ready_table.sv
module tb_phy_reg_ready_table;
    import phy_reg_ready_table_pkg::*;

    logic                                   clk = 1'b0;
    logic                                   rst;
    execute_feedback_pack_t                 fb;
    logic [RENAME_WIDTH-1:0]                av;
    logic [RENAME_WIDTH-1:0][PHY_ID_W-1:0]  aid;
    logic                                   flush;
    logic [READ_PORT_NUM-1:0][PHY_ID_W-1:0] rid;
    logic [READ_PORT_NUM-1:0]               rr;
    logic [PHY_REG_NUM-1:0]                 bm;

    logic [PHY_REG_NUM-1:0] model;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phy_reg_ready_table dut (
        .clk                   (clk),
        .rst                   (rst),
        .execute_feedback_pack (fb),
        .rename_alloc_valid    (av),
        .rename_alloc_phy_id   (aid),
        .flush                 (flush),
        .read_phy_id           (rid),
        .read_ready            (rr),
        .ready_bitmap          (bm)
    );

    task automatic check_eq(input string tag, input logic [PHY_REG_NUM-1:0] obs,
                            input logic [PHY_REG_NUM-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit fb_targets(input int r);
        for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++)
            if (fb[c].enable && int'(fb[c].phy_id) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit alloc_targets(input int r);
        for (int i = 0; i < RENAME_WIDTH; i++)
            if (av[i] && int'(aid[i]) == r) return 1'b1;
        return 1'b0;
    endfunction

    // Expected query result: stored readiness or a result arriving this cycle.
    function automatic logic [READ_PORT_NUM-1:0] exp_read();
        logic [READ_PORT_NUM-1:0] e;
        for (int p = 0; p < READ_PORT_NUM; p++)
            e[p] = model[rid[p]] | fb_targets(int'(rid[p]));
        return e;
    endfunction

    task automatic model_step();
        logic [PHY_REG_NUM-1:0] nxt;
        for (int r = 0; r < PHY_REG_NUM; r++) begin
            if (r == 0 || flush)        nxt[r] = 1'b1;
            else if (alloc_targets(r))  nxt[r] = 1'b0;
            else if (fb_targets(r))     nxt[r] = 1'b1;
            else                        nxt[r] = model[r];
        end
        model = nxt;
    endtask

    task automatic idle();
        fb = '0; av = '0; aid = '0; flush = 1'b0;
    endtask

    // Inputs are driven 1 time unit after a rising edge; this checks the
    // combinational ports mid-cycle, then the registered bitmap after the edge.
    task automatic cycle();
        #3;
        check_eq("read_ready", PHY_REG_NUM'(rr), PHY_REG_NUM'(exp_read()));
        @(posedge clk);
        model_step();
        #1;
        check_eq("ready_bitmap", bm, model);
    endtask

    task automatic rand_inputs();
        bit ok;
        idle();
        for (int p = 0; p < READ_PORT_NUM; p++) rid[p] = PHY_ID_W'($urandom_range(0, 31));
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            av[i] = ($urandom_range(0, 2) == 0);
            ok = 1'b0;
            while (!ok) begin
                aid[i] = PHY_ID_W'($urandom_range(0, 31));
                ok = 1'b1;
                for (int j = 0; j < i; j++)
                    if (av[i] && av[j] && aid[j] == aid[i] && aid[i] != '0) ok = 1'b0;
            end
        end
        for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
            fb[c].enable = ($urandom_range(0, 2) == 0);
            fb[c].value  = VALUE_W'($urandom);
            ok = 1'b0;
            while (!ok) begin
                fb[c].phy_id = PHY_ID_W'($urandom_range(0, 31));
                ok = 1'b1;
                for (int i = 0; i < RENAME_WIDTH; i++)
                    if (av[i] && aid[i] == fb[c].phy_id && aid[i] != '0) ok = 1'b0;
            end
        end
        flush = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        // Reset held for three cycles.
        rst = 1'b0;
        idle();
        for (int p = 0; p < READ_PORT_NUM; p++) rid[p] = PHY_ID_W'(37);
        model = '1;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_bitmap_in_reset", bm, '1);
        rst = 1'b1;
        #1;
        check_eq("reset_bitmap", bm, '1);
        check_eq("reset_read37", PHY_REG_NUM'(rr), PHY_REG_NUM'({READ_PORT_NUM{1'b1}}));
        @(posedge clk); #1;

        // Allocate 37, then wake it four cycles later on channel 5.
        av[0] = 1'b1; aid[0] = PHY_ID_W'(37);
        cycle();
        check_eq("alloc37_bit", PHY_REG_NUM'(bm[37]), '0);
        idle();
        #2;
        check_eq("alloc37_read", PHY_REG_NUM'(rr[0]), '0);
        cycle();
        idle(); cycle();
        idle(); cycle();
        fb[5].enable = 1'b1; fb[5].phy_id = PHY_ID_W'(37); fb[5].value = 32'hdead_beef;
        #2;
        check_eq("wake37_bypass", PHY_REG_NUM'(rr[3]), PHY_REG_NUM'(1));
        check_eq("wake37_bit_before_edge", PHY_REG_NUM'(bm[37]), '0);
        cycle();
        check_eq("wake37_bit", PHY_REG_NUM'(bm[37]), PHY_REG_NUM'(1));

        // Four allocations in one cycle, then a duplicate wake of 12.
        idle();
        av = '1;
        for (int i = 0; i < RENAME_WIDTH; i++) aid[i] = PHY_ID_W'(10 + i);
        for (int p = 0; p < READ_PORT_NUM; p++) rid[p] = PHY_ID_W'(10 + (p % 4));
        cycle();
        idle();
        fb[0].enable = 1'b1; fb[0].phy_id = PHY_ID_W'(12);
        fb[7].enable = 1'b1; fb[7].phy_id = PHY_ID_W'(12);
        cycle();
        check_eq("multi_alloc_bits", PHY_REG_NUM'(bm[13:10]), PHY_REG_NUM'(4'b0100));

        // Flush beats a same-cycle allocate and feedback.
        idle();
        av[0] = 1'b1; aid[0] = PHY_ID_W'(20);
        av[1] = 1'b1; aid[1] = PHY_ID_W'(21);
        for (int p = 0; p < READ_PORT_NUM; p++) rid[p] = PHY_ID_W'(20 + (p % 3));
        cycle();
        check_eq("flush_pre_bits", PHY_REG_NUM'(bm[21:20]), '0);
        idle();
        flush = 1'b1;
        av[0] = 1'b1; aid[0] = PHY_ID_W'(22);
        fb[1].enable = 1'b1; fb[1].phy_id = PHY_ID_W'(20);
        cycle();
        check_eq("flush_bits", PHY_REG_NUM'(bm[22:20]), PHY_REG_NUM'(3'b111));

        // Register 0 stays ready even when allocated.
        idle();
        rid = '0;
        av[0] = 1'b1; aid[0] = '0;
        #2;
        check_eq("reg0_read", PHY_REG_NUM'(rr), PHY_REG_NUM'({READ_PORT_NUM{1'b1}}));
        cycle();
        check_eq("reg0_bit", PHY_REG_NUM'(bm[0]), PHY_REG_NUM'(1));
        idle();
        cycle();

        // Randomized legal traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            cycle();
        end

        // Clear 50 registers, then drop reset between edges.
        idle();
        for (int k = 0; k < 50; k += RENAME_WIDTH) begin
            av = '0;
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (k + i < 50) begin
                    av[i]  = 1'b1;
                    aid[i] = PHY_ID_W'(60 + k + i);
                end
            end
            cycle();
        end
        idle();
        check_eq("fifty_cleared", PHY_REG_NUM'(bm[109:60]), '0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_bitmap", bm, '1);
        model = '1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_reset_bitmap", bm, '1);
        av[0] = 1'b1; aid[0] = PHY_ID_W'(77);
        rid = '0; rid[0] = PHY_ID_W'(77);
        cycle();
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
